// File: rtl/alu_4.sv
// alu_4 : 4-bit registered ALU with push-button entry and an optional
// HD44780-compatible 4-bit character LCD driver.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   push1/push2/push3 asynchronous buttons: load A / B / opcode from no
//   no[3:0]           shared operand/opcode switches
//   res[3:0]          registered ALU result
//   cout              carry / borrow / shift-out of the current operation
//   cf                carry flag (changes only on ADD, SUB, SHL, SHR)
//   zf, sf            zero flag (res == 0), sign flag (res[3])
//   sf_e              StrataFlash disable, constant 1
//   e, rs, rw         LCD enable, register select, read/write (rw constant 0)
//   d, c, b2, a2      LCD data nibble, bits 3..0
//
// Build option: define ALU4_LCD_EN to compile in the LCD FSM. Without it the
// LCD outputs are tied low and only the ALU is built.
module alu_4 #(
  parameter int CLK_MHZ = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push1,
  input  logic       push2,
  input  logic       push3,
  input  logic [3:0] no,
  output logic [3:0] res,
  output logic       cout,
  output logic       cf,
  output logic       zf,
  output logic       sf,
  output logic       sf_e,
  output logic       e,
  output logic       rs,
  output logic       rw,
  output logic       d,
  output logic       c,
  output logic       b2,
  output logic       a2
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7
  } alu_op_e;

  // Button synchronisers: two metastability flops plus one history flop
  // for rising-edge detection. Bit order {push3, push2, push1}.
  logic [2:0] push_s1, push_s2, push_s3;
  logic [2:0] push_rise;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_s1 <= '0;
      push_s2 <= '0;
      push_s3 <= '0;
    end else begin
      push_s1 <= {push3, push2, push1};
      push_s2 <= push_s1;
      push_s3 <= push_s2;
    end
  end

  assign push_rise = push_s2 & ~push_s3;

  logic [3:0] a_q, b_q;
  alu_op_e    op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      if (push_rise[0]) a_q  <= no;
      if (push_rise[1]) b_q  <= no;
      if (push_rise[2]) op_q <= alu_op_e'(no);
    end
  end

  logic [4:0] sum5, diff5;
  logic [3:0] alu_res;
  logic       alu_cout;
  logic       carry_op;

  assign sum5  = {1'b0, a_q} + {1'b0, b_q};
  assign diff5 = {1'b0, a_q} - {1'b0, b_q};  // bit 4 set means A < B

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    alu_res  = a_q;
    alu_cout = 1'b0;
    carry_op = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum5[3:0];  alu_cout = sum5[4];  carry_op = 1'b1; end
      OP_SUB: begin alu_res = diff5[3:0]; alu_cout = diff5[4]; carry_op = 1'b1; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin alu_res = {a_q[2:0], 1'b0}; alu_cout = a_q[3]; carry_op = 1'b1; end
      OP_SHR: begin alu_res = {1'b0, a_q[3:1]}; alu_cout = a_q[0]; carry_op = 1'b1; end
      default: ;  // opcodes 8..15 pass A through
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res  <= '0;
      cout <= 1'b0;
      cf   <= 1'b0;
      zf   <= 1'b0;
      sf   <= 1'b0;
    end else begin
      res  <= alu_res;
      cout <= alu_cout;
      if (carry_op) cf <= alu_cout;
      zf   <= (alu_res == 4'd0);
      sf   <= alu_res[3];
    end
  end

  assign sf_e = 1'b1;
  assign rw   = 1'b0;

`ifdef ALU4_LCD_EN
  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_WAIT, CMD, CLR_WAIT, ADDR, CHAR, BYTE_GAP
  } lcd_state_e;

  localparam int CW = $clog2(15000 * CLK_MHZ + 1);
  localparam logic [3:0] FIRST_CHAR = 4'd5;
  localparam logic [3:0] LAST_CHAR  = 4'd12;

  // idx walks the whole script: 0..3 init nibbles / init commands,
  // 4 = DDRAM address command, 5..12 = the eight display characters.
  lcd_state_e    state, state_n;
  logic [3:0]    idx, idx_n;
  logic [CW-1:0] cnt, lim;
  logic [2:0]    step;
  logic [7:0]    byte_q;
  logic          tick, nib_done, byte_done;
  logic          e_n, rs_n;
  logic [3:0]    nib_n, nib_q;

  function automatic logic [7:0] lcd_byte(input logic [3:0] i, input logic [3:0] r,
                                          input logic f_c, input logic f_z, input logic f_s);
    case (i)
      4'd0:    lcd_byte = 8'h28;
      4'd1:    lcd_byte = 8'h06;
      4'd2:    lcd_byte = 8'h0C;
      4'd3:    lcd_byte = 8'h01;
      4'd4:    lcd_byte = 8'h80;
      4'd5:    lcd_byte = {7'b0011000, r[3]};
      4'd6:    lcd_byte = {7'b0011000, r[2]};
      4'd7:    lcd_byte = {7'b0011000, r[1]};
      4'd8:    lcd_byte = {7'b0011000, r[0]};
      4'd10:   lcd_byte = {7'b0011000, f_c};
      4'd11:   lcd_byte = {7'b0011000, f_z};
      4'd12:   lcd_byte = {7'b0011000, f_s};
      default: lcd_byte = 8'h20;
    endcase
  endfunction

  // Wait states count their whole delay; transfer states count 1 us per step.
  always_comb begin
    lim = CW'(CLK_MHZ - 1);
    case (state)
      PWR_WAIT:  lim = CW'(15000 * CLK_MHZ - 1);
      INIT_WAIT: case (idx)
                   4'd0:    lim = CW'(4100 * CLK_MHZ - 1);
                   4'd1:    lim = CW'(100 * CLK_MHZ - 1);
                   default: lim = CW'(40 * CLK_MHZ - 1);
                 endcase
      CLR_WAIT:  lim = CW'(1640 * CLK_MHZ - 1);
      BYTE_GAP:  lim = CW'(40 * CLK_MHZ - 1);
      default:   ;
    endcase
  end

  assign tick      = (cnt == lim);
  assign nib_done  = tick && (step == 3'd2);
  assign byte_done = tick && (step == 3'd6);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= PWR_WAIT;
      idx    <= '0;
      cnt    <= '0;
      step   <= '0;
      byte_q <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= tick ? '0 : cnt + 1'b1;
      step  <= (state_n != state) ? 3'd0 : (tick ? step + 3'd1 : step);
      // Snapshot the byte (and so res/flags) at the moment its transfer starts.
      if ((state_n != state) && (state_n == CMD || state_n == ADDR || state_n == CHAR))
        byte_q <= lcd_byte(idx_n, res, cf, zf, sf);
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      PWR_WAIT:  if (tick) begin state_n = INIT_NIB; idx_n = '0; end
      INIT_NIB:  if (nib_done) state_n = INIT_WAIT;
      INIT_WAIT: if (tick) begin
                   if (idx == 4'd3) begin state_n = CMD; idx_n = '0; end
                   else begin state_n = INIT_NIB; idx_n = idx + 4'd1; end
                 end
      CMD:       if (byte_done) state_n = (idx == 4'd3) ? CLR_WAIT : BYTE_GAP;
      CLR_WAIT:  if (tick) begin state_n = ADDR; idx_n = 4'd4; end
      ADDR,
      CHAR:      if (byte_done) state_n = BYTE_GAP;
      BYTE_GAP:  if (tick) begin
                   if (idx <= 4'd2) begin state_n = CMD; idx_n = idx + 4'd1; end
                   else if (idx == LAST_CHAR) begin state_n = ADDR; idx_n = 4'd4; end
                   else begin state_n = CHAR; idx_n = (idx < FIRST_CHAR) ? FIRST_CHAR : idx + 4'd1; end
                 end
      default:   begin state_n = PWR_WAIT; idx_n = '0; end
    endcase
  end

  // Output decode. Byte steps: 0 setup, 1 e high, 2 hold (high nibble),
  // 3 inter-nibble gap, 4 setup, 5 e high, 6 hold (low nibble).
  always_comb begin
    e_n   = 1'b0;
    rs_n  = 1'b0;
    nib_n = 4'h0;
    case (state)
      INIT_NIB: begin
        nib_n = (idx == 4'd3) ? 4'h2 : 4'h3;
        e_n   = (step == 3'd1);
      end
      CMD, ADDR, CHAR: begin
        rs_n  = (state == CHAR);
        nib_n = (step < 3'd4) ? byte_q[7:4] : byte_q[3:0];
        e_n   = (step == 3'd1) || (step == 3'd5);
      end
      default: ;
    endcase
  end

  // Registered pins keep e glitch-free; reset still clears them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e     <= 1'b0;
      rs    <= 1'b0;
      nib_q <= '0;
    end else begin
      e     <= e_n;
      rs    <= rs_n;
      nib_q <= nib_n;
    end
  end

  assign {d, c, b2, a2} = nib_q;
`else
  assign e  = 1'b0;
  assign rs = 1'b0;
  assign d  = 1'b0;
  assign c  = 1'b0;
  assign b2 = 1'b0;
  assign a2 = 1'b0;
`endif

endmodule

// File: tb/tb_alu_4.sv
// tb_alu_4 : self-checking bench for alu_4. Button presses feed a reference
// model whose expected outputs are queued with the cycle they are due; a
// negedge monitor pops and compares them. With ALU4_LCD_EN defined the LCD
// init sequence, refresh bytes and reset-abort are checked as well.
module tb_alu_4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push1 = 1'b0, push2 = 1'b0, push3 = 1'b0;
  logic [3:0] no = 4'd0;
  logic [3:0] res;
  logic       cout, cf, zf, sf, sf_e, e, rs, rw, d, c, b2, a2;

  alu_4 #(.CLK_MHZ(1)) dut (
    .clk(clk), .reset(reset), .push1(push1), .push2(push2), .push3(push3), .no(no),
    .res(res), .cout(cout), .cf(cf), .zf(zf), .sf(sf), .sf_e(sf_e),
    .e(e), .rs(rs), .rw(rw), .d(d), .c(c), .b2(b2), .a2(a2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         due;
    string      tag;
    logic [3:0] res;
    logic       cout, cf, zf, sf;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       m_out;
  logic [3:0] m_a = 4'd0, m_b = 4'd0, m_op = 4'd0;

  function automatic exp_t alu_model(input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] op, input logic cf_old);
    exp_t x;
    int   s;
    x.cout = 1'b0;
    case (op)
      4'd0: begin s = int'(a) + int'(b); x.res = s[3:0]; x.cout = (s > 15); end
      4'd1: begin s = int'(a) - int'(b) + 16; x.res = s[3:0]; x.cout = (a < b); end
      4'd2: x.res = a & b;
      4'd3: x.res = a | b;
      4'd4: x.res = a ^ b;
      4'd5: x.res = 4'hF - a;
      4'd6: begin x.res = (a * 2) % 16; x.cout = a[3]; end
      4'd7: begin x.res = a / 2; x.cout = a[0]; end
      default: x.res = a;
    endcase
    x.cf  = (op == 4'd0 || op == 4'd1 || op == 4'd6 || op == 4'd7) ? x.cout : cf_old;
    x.zf  = (x.res == 4'd0);
    x.sf  = (x.res >= 4'd8);
    x.due = 0;
    x.tag = "";
    return x;
  endfunction

  // Scoreboard monitor: compare every expectation on its due cycle.
  always @(negedge clk) begin : sb_mon
    exp_t x;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      x = sb_q.pop_front();
      check({x.tag, "_due"},  x.due,  cyc);
      check({x.tag, "_res"},  res,  x.res);
      check({x.tag, "_cout"}, cout, x.cout);
      check({x.tag, "_cf"},   cf,   x.cf);
      check({x.tag, "_zf"},   zf,   x.zf);
      check({x.tag, "_sf"},   sf,   x.sf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press buttons in mask {push3,push2,push1} for two clocks; expect the old
  // outputs 3 clocks later and the new ones 4 clocks later.
  task automatic press(input logic [2:0] mask, input logic [3:0] val, input string tag);
    exp_t pre, nxt;
    pre = m_out;
    pre.due = cyc + 3;
    pre.tag = {tag, "_pre"};
    if (mask[0]) m_a = val;
    if (mask[1]) m_b = val;
    if (mask[2]) m_op = val;
    nxt = alu_model(m_a, m_b, m_op, m_out.cf);
    nxt.due = cyc + 4;
    nxt.tag = tag;
    sb_q.push_back(pre);
    sb_q.push_back(nxt);
    m_out = nxt;
    no = val;
    {push3, push2, push1} = mask;
    tick(); tick();
    {push3, push2, push1} = 3'b000;
    repeat (4) tick();
  endtask

  // LCD enable-pulse capture: data/rs sampled while e is high.
  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         cyc;
  } pulse_t;

  pulse_t pulse_q[$];
  logic   e_prev = 1'b0;

  always @(negedge clk) begin : lcd_mon
    pulse_t p;
    if (e && !e_prev) begin
      p.rs  = rs;
      p.nib = {d, c, b2, a2};
      p.cyc = cyc;
      pulse_q.push_back(p);
    end
    e_prev = e;
  end

  task automatic get_pulse(output pulse_t p, output logic ok, input int budget);
    p.rs = 1'b0; p.nib = 4'h0; p.cyc = 0;
    for (int n = 0; n < budget && pulse_q.size() == 0; n++) @(negedge clk);
    ok = (pulse_q.size() > 0);
    if (ok) p = pulse_q.pop_front();
  endtask

  task automatic get_byte(output logic brs, output logic [7:0] bval, input string tag);
    pulse_t hi, lo;
    logic   ok_hi, ok_lo;
    get_pulse(hi, ok_hi, 2000);
    get_pulse(lo, ok_lo, 2000);
    check({tag, "_seen"}, ok_hi && ok_lo, 1);
    check({tag, "_rs_pair"}, lo.rs, hi.rs);
    brs  = hi.rs;
    bval = {hi.nib, lo.nib};
  endtask

  int rel_cyc;

  initial begin : main
    exp_t held;
    // Reset held three clocks.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res", res, 0);
    check("rst_cout", cout, 0);
    check("rst_cf", cf, 0);
    check("rst_zf", zf, 0);
    check("rst_sf", sf, 0);
    check("rst_sf_e", sf_e, 1);
    check("rst_rw", rw, 0);
    check("rst_e", e, 0);
    check("rst_rs", rs, 0);
    check("rst_nib", {d, c, b2, a2}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    rel_cyc = cyc;
    @(negedge clk);
    check("rel_zf_hold", zf, 0);
    @(negedge clk);
    check("rel_zf", zf, 1);
    check("rel_res", res, 0);
    m_out = alu_model(4'd0, 4'd0, 4'd0, 1'b0);
    tick();

    // ALU operations.
    press(3'b001, 4'b0001, "add_a");
    press(3'b010, 4'b1100, "add_b");
    press(3'b100, 4'd0,    "add");
    press(3'b100, 4'd1,    "sub");
    press(3'b100, 4'd2,    "and");
    press(3'b001, 4'b1001, "and_a9");
    press(3'b100, 4'd6,    "shl");
    press(3'b100, 4'd7,    "shr");
    press(3'b100, 4'd3,    "or");
    press(3'b100, 4'd4,    "xor");
    press(3'b100, 4'd5,    "not");
    press(3'b100, 4'd15,   "pass");
    press(3'b100, 4'd0,    "add_carry");
    press(3'b010, 4'd0,    "add_nocarry");
    press(3'b011, 4'b0111, "simul");
    press(3'b100, 4'd1,    "sub_eq");

    // Held button: A loads 0011 once; later changes of no are ignored.
    m_a = 4'b0011;
    held = alu_model(m_a, m_b, m_op, m_out.cf);
    begin
      exp_t pre;
      pre = m_out; pre.due = cyc + 3; pre.tag = "held_pre"; sb_q.push_back(pre);
      held.tag = "held_load";  held.due = cyc + 4;  sb_q.push_back(held);
      held.tag = "held_mid";   held.due = cyc + 20; sb_q.push_back(held);
      held.tag = "held_after"; held.due = cyc + 26; sb_q.push_back(held);
    end
    m_out = held;
    no = 4'b0011;
    push1 = 1'b1;
    repeat (4) tick();
    no = 4'b1111;
    repeat (16) tick();
    push1 = 1'b0;
    repeat (8) tick();

    // Leave res = 1101 with cf = 0 for the LCD refresh check.
    press(3'b001, 4'b0001, "fin_a");
    press(3'b010, 4'b1100, "fin_b");
    press(3'b100, 4'd0,    "fin_add");
    repeat (2) tick();
    check("sb_drain", sb_q.size(), 0);

`ifdef ALU4_LCD_EN
    begin
      pulse_t     p;
      logic       ok, brs;
      logic [7:0] bval;
      logic [8:0] lcd_exp[$];
      logic [8:0] x;
      logic [3:0] init_nib[4];

      get_pulse(p, ok, 20000);
      check("lcd_first_seen", ok, 1);
      check("lcd_first_nib", p.nib, 4'h3);
      check("lcd_first_rs", p.rs, 0);
      check("lcd_pwr_delay_ok", (p.cyc - rel_cyc) >= 15000, 1);
      init_nib[1] = 4'h3; init_nib[2] = 4'h3; init_nib[3] = 4'h2;
      for (int i = 1; i < 4; i++) begin
        get_pulse(p, ok, 6000);
        check($sformatf("lcd_init%0d_seen", i), ok, 1);
        check($sformatf("lcd_init%0d_nib", i), p.nib, init_nib[i]);
        check($sformatf("lcd_init%0d_rs", i), p.rs, 0);
      end

      lcd_exp = '{9'h028, 9'h006, 9'h00C, 9'h001, 9'h080,
                  9'h131, 9'h131, 9'h130, 9'h131, 9'h120, 9'h130, 9'h130, 9'h131};
      for (int i = 0; i < 13; i++) begin
        get_byte(brs, bval, $sformatf("lcd_byte%0d", i));
        x = lcd_exp.pop_front();
        check($sformatf("lcd_byte%0d_rs", i), brs, x[8]);
        check($sformatf("lcd_byte%0d_val", i), bval, x[7:0]);
      end

      // Reset while e is high during a character byte.
      ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
        @(negedge clk);
        if (e && rs) ok = 1'b1;
      end
      check("lcd_midbyte_seen", ok, 1);
      reset = 1'b1;
      #1;
      check("lcd_rst_e_drop", e, 0);
      check("lcd_rst_rs", rs, 0);
      check("lcd_rst_res", res, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      rel_cyc = cyc;
      pulse_q.delete();
      get_pulse(p, ok, 20000);
      check("lcd_restart_seen", ok, 1);
      check("lcd_restart_nib", p.nib, 4'h3);
      check("lcd_restart_rs", p.rs, 0);
      check("lcd_restart_delay_ok", (p.cyc - rel_cyc) >= 15000, 1);
    end
`else
    check("nolcd_e", e, 0);
    check("nolcd_rs", rs, 0);
    check("nolcd_nib", {d, c, b2, a2}, 0);
    check("nolcd_rw", rw, 0);
    check("nolcd_sf_e", sf_e, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation limit reached (cycle %0d)", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/alu_4.md
# alu_4

4-bit registered ALU with push-button operand/opcode entry and an HD44780-compatible 4-bit LCD driver. It is intended for a Spartan-3E class board. Three push buttons each latch the shared 4-bit `no` input into operand A, operand B or the opcode register. The result and flags are registered and also shown continuously on the character LCD.

## Interface
- `CLK_MHZ`, default 50: clock frequency in MHz. Every LCD delay is specified in µs and implemented as µs × `CLK_MHZ` cycles.
- `clk`, input, 1 bit: system clock. All logic is on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `push1`, input, 1 bit: button that loads operand A from `no`. Asynchronous.
- `push2`, input, 1 bit: button that loads operand B from `no`. Asynchronous.
- `push3`, input, 1 bit: button that loads the opcode from `no`. Asynchronous.
- `no`, input, 4 bits: shared data/opcode switches.
- `res`, output, 4 bits: registered ALU result.
- `cout`, output, 1 bit: carry/borrow/shift-out of the current operation.
- `cf`, output, 1 bit: carry flag, updated only by carry-producing operations.
- `zf`, output, 1 bit: zero flag, `res == 0`.
- `sf`, output, 1 bit: sign flag, `res[3]`.
- `sf_e`, output, 1 bit: StrataFlash disable. Constant 1.
- `e`, output, 1 bit: LCD enable strobe.
- `rs`, output, 1 bit: LCD register select. 0 = command, 1 = data.
- `rw`, output, 1 bit: LCD read/write. Constant 0 (write only).
- `d`, `c`, `b2`, `a2`, outputs, 1 bit each: LCD data nibble, bits 3, 2, 1, 0 respectively.

## Operation
- **Input synchronisation:** each `pushN` passes through a 2-FF synchroniser followed by a rising-edge detector. On a detected edge, the target register loads `no`.
- **Simultaneous pushes:** every register with a detected edge loads the same `no` value.
- **Held button:** a button held high loads once only.
- **Opcode map (ALU, operands A and B):**
  - 0 ADD: `res = A+B`; `cout` = carry out.
  - 1 SUB: `res = A-B` (mod 16); `cout` = 1 when A < B (borrow).
  - 2 AND, 3 OR, 4 XOR: `cout` = 0.
  - 5 NOT A: `cout` = 0.
  - 6 SHL A: `res = {A[2:0],0}`; `cout = A[3]`.
  - 7 SHR A: `res = {0,A[3:1]}`; `cout = A[0]`.
  - 8–15 PASS A: `cout` = 0.
- **Flag updates:**
  - `cf` loads `cout` only for opcodes 0, 1, 6 and 7; for all other opcodes it holds its value.
  - `zf` and `sf` are recomputed from the new `res` every cycle.
- **Result register:** `res`, `cout`, `cf`, `zf` and `sf` are registered and updated every clock from the current A, B and opcode registers.
- **LCD power-up initialisation:** the FSM runs this sequence once:
  - wait 15000 µs;
  - nibble 0x3, wait 4100 µs;
  - nibble 0x3, wait 100 µs;
  - nibble 0x3, wait 40 µs;
  - nibble 0x2, wait 40 µs;
  - commands 0x28, 0x06, 0x0C, 0x01, then wait 1640 µs.
- **LCD refresh loop:** repeats forever.
  - Command 0x80.
  - Then 8 data bytes: ASCII `'0'`/`'1'` for `res[3]`..`res[0]`, a space, then `cf`, `zf`, `sf` as `'0'`/`'1'`.
  - Each character reflects `res`/flags sampled when that byte starts.
- **Nibble write:**
  - drive `rs` and the nibble;
  - after 1 µs setup, hold `e` high for 1 µs, then low;
  - hold data 1 µs after `e` falls.
- **Byte write:** high nibble, wait 1 µs, low nibble, then wait 40 µs before the next byte.
- **FSM states:** `PWR_WAIT`, `INIT_NIB`, `INIT_WAIT`, `CMD`, `CLR_WAIT`, `ADDR`, `CHAR`, `BYTE_GAP`.

## Timing
- **Reset values:**
  - A, B, opcode, `res`, `cout`, `cf`, `zf`, `sf`, `e`, `rs`, `d`, `c`, `b2`, `a2`: all 0.
  - `rw`: 0. `sf_e`: 1.
  - LCD FSM: `PWR_WAIT` with the delay counter cleared.
- **Reset mid-operation:** reset asserted during any LCD state aborts the transfer, drops `e` immediately, and restarts the full initialisation after release.
- **Reset and ALU flags:** after reset with opcode 0 and A = B = 0, the first clock gives `res=0`, `zf=1`.
- **Push-to-register latency:** 3 clocks from a `pushN` rising edge to the operand/opcode register (2 sync + 1 load).
- **Push-to-result latency:** 4 clocks from a push rising edge to `res`/flags.
- **Minimum push width:** a push must be high for at least 2 clocks to be detected. Narrower pulses are not required to load.
- **LCD timing:** all LCD delays are at least the stated µs at `CLK_MHZ`. `e` high time is at least `CLK_MHZ` cycles.

## Configuration
- **`ALU4_LCD_EN` defined:** the LCD FSM is compiled in and behaves as described above.
- **`ALU4_LCD_EN` undefined:**
  - no LCD FSM;
  - `e`, `rs`, `d`, `c`, `b2`, `a2` tied to 0;
  - `rw` = 0 and `sf_e` = 1;
  - ALU behaviour unchanged.

## Test plan
- **Reset:** assert `reset` for 3 clocks → all outputs at their reset values (`sf_e`=1), `zf`=1 one clock after release.
- **ADD:** push1 with `no`=0001, push2 with `no`=1100, push3 with `no`=0000 → 4 clocks after push3: `res`=1101, `cout`=0, `cf`=0, `zf`=0, `sf`=1.
- **SUB then AND:**
  - Operands as above, opcode 1 → `res`=0101, `cout`=1, `cf`=1, `sf`=0.
  - Then opcode 2 → `res`=0000, `zf`=1, `cout`=0, `cf` stays 1.
- **Shifts:** A=1001 with opcode 6 → `res`=0010, `cout`=1; with opcode 7 → `res`=0100, `cout`=1.
- **Simultaneous pushes and held button:**
  - push1 and push2 together with `no`=0111 → A=B=0111.
  - push1 held 20 clocks while `no` changes after the load → A keeps its first value.
- **LCD** (`ALU4_LCD_EN`, `CLK_MHZ`=1):
  - first `e` pulse carries nibble 0x3 with `rs`=0 after at least 15000 cycles;
  - with `res`=1101, the refresh loop emits data bytes 0x31, 0x31, 0x30, 0x31 with `rs`=1;
  - reset mid-byte drops `e` at once and restarts the init sequence.
